// File: rtl/interp_mem_pkg.sv
// Shared definitions for the interpolation memory responder: word address map
// of the m/t0/t1/u table and the ownership state encoding.
package interp_mem_pkg;

  localparam logic [15:0] M_ADDR   = 16'h0000;
  localparam logic [15:0] T0_ADDR  = 16'h0001;
  localparam logic [15:0] T1_ADDR  = 16'h0002;
  localparam logic [15:0] U0_ADDR  = 16'h000A;
  localparam logic [15:0] U_OFFSET = 16'h0200;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/dp_ram_1w2r.sv
// One write port, two registered read ports (read-first), 1-cycle read latency.
// Read registers hold while their enable is low; the array itself is never reset.
module dp_ram_1w2r #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata2
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] rd1_q;
  logic [W-1:0] rd2_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Both reads sample the array before this edge's write lands: read-first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (re1) rd1_q <= mem[raddr1];
      if (re2) rd2_q <= mem[raddr2];
    end
  end

  assign rdata1 = rd1_q;
  assign rdata2 = rd2_q;

endmodule

// File: rtl/interp_mem_responder.sv
// Table memory for the interpolation engine; host owns it in IDLE, engine in SERVE.
// Engine/host reads: 1 cycle latency. Host is stalled (host_ready low) while run is seen or engine owns memory.
module interp_mem_responder
  import interp_mem_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH_LOG2    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_add1,
  input  logic [ADDRESS_WIDTH-1:0] ram_add2,
  input  logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     data_to_ram,
  output logic [WORD_SIZE-1:0]     ram_data1,
  output logic [WORD_SIZE-1:0]     ram_data2,
  input  logic                     run,
  input  logic                     done_sg,
  output logic                     busy,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     host_we,
  input  logic [ADDRESS_WIDTH-1:0] host_addr,
  input  logic [WORD_SIZE-1:0]     host_wdata,
  output logic                     host_rvalid,
  output logic [WORD_SIZE-1:0]     host_rdata,
  output logic                     addr_err,
  output logic [ADDRESS_WIDTH-1:0] wr_count
);

  function automatic logic oor(input logic [ADDRESS_WIDTH-1:0] a);
    return |a[ADDRESS_WIDTH-1:DEPTH_LOG2];
  endfunction

  state_e                   state_q, state_d;
  logic                     oor1_q, oor2_q;
  logic                     src_host_q, src_host_d;
  logic [WORD_SIZE-1:0]     eng2_hold_q, eng2_hold_d;
  logic [WORD_SIZE-1:0]     host_hold_q, host_hold_d;
  logic                     host_rvalid_q;
  logic                     addr_err_q, addr_err_d;
  logic [ADDRESS_WIDTH-1:0] wr_count_q, wr_count_d;

  logic                     serve, run_go, host_acc, host_rd, host_wr;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic                     we, re2;
  logic [WORD_SIZE-1:0]     wdata, rd1, rd2, data1, data2;

  assign serve      = (state_q == SERVE);
  assign run_go     = (state_q == IDLE) & run;
  assign host_ready = (state_q == IDLE) & ~run;
  assign host_acc   = host_valid & host_ready;
  assign host_rd    = host_acc & ~host_we;
  assign host_wr    = host_acc & host_we;

  // Read port 2 is shared: engine port 2 in SERVE, host reads in IDLE.
  assign addr2 = serve ? ram_add2 : host_addr;
  assign re2   = serve | host_rd;
  assign we    = serve ? (mem_write & ~oor(ram_add2)) : (host_wr & ~oor(host_addr));
  assign wdata = serve ? data_to_ram : host_wdata;

  dp_ram_1w2r #(.W(WORD_SIZE), .AW(DEPTH_LOG2)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (addr2[DEPTH_LOG2-1:0]),
    .wdata  (wdata),
    .re1    (serve),
    .raddr1 (ram_add1[DEPTH_LOG2-1:0]),
    .rdata1 (rd1),
    .re2    (re2),
    .raddr2 (addr2[DEPTH_LOG2-1:0]),
    .rdata2 (rd2)
  );

  assign data1 = oor1_q ? '0 : rd1;
  assign data2 = oor2_q ? '0 : rd2;

  always_comb begin
    state_d     = state_q;
    src_host_d  = src_host_q;
    eng2_hold_d = eng2_hold_q;
    host_hold_d = host_hold_q;
    addr_err_d  = addr_err_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      IDLE:    if (run) state_d = SERVE;
      SERVE:   if (done_sg) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Whoever takes over port 2 first parks the other agent's last result.
    if (host_rd && !src_host_q) begin
      eng2_hold_d = data2;
      src_host_d  = 1'b1;
    end else if (serve && src_host_q) begin
      host_hold_d = data2;
      src_host_d  = 1'b0;
    end
    if (run_go) begin
      addr_err_d = 1'b0;
      wr_count_d = '0;
    end else begin
      if ((serve && (oor(ram_add1) || oor(ram_add2))) || (host_acc && oor(host_addr)))
        addr_err_d = 1'b1;
      if (serve && mem_write) wr_count_d = wr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      oor1_q        <= 1'b0;
      oor2_q        <= 1'b0;
      src_host_q    <= 1'b0;
      eng2_hold_q   <= '0;
      host_hold_q   <= '0;
      host_rvalid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      src_host_q    <= src_host_d;
      eng2_hold_q   <= eng2_hold_d;
      host_hold_q   <= host_hold_d;
      host_rvalid_q <= host_rd;
      addr_err_q    <= addr_err_d;
      wr_count_q    <= wr_count_d;
      if (serve) oor1_q <= oor(ram_add1);
      if (re2)   oor2_q <= oor(addr2);
    end
  end

  assign ram_data1   = data1;
  assign ram_data2   = src_host_q ? eng2_hold_q : data2;
  assign host_rdata  = src_host_q ? data2 : host_hold_q;
  assign host_rvalid = host_rvalid_q;
  assign busy        = serve;
  assign addr_err    = addr_err_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_interp_mem_responder.sv
// Directed bench for interp_mem_responder: inputs change and outputs are
// sampled on the falling edge, away from the rising active edge.
module tb_interp_mem_responder;
  import interp_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_add1, ram_add2, data_to_ram, host_addr, host_wdata;
  logic        mem_write, run, done_sg, host_valid, host_we;
  logic [15:0] ram_data1, ram_data2, host_rdata, wr_count;
  logic        busy, host_ready, host_rvalid, addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interp_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .ram_add1    (ram_add1),
    .ram_add2    (ram_add2),
    .mem_write   (mem_write),
    .data_to_ram (data_to_ram),
    .ram_data1   (ram_data1),
    .ram_data2   (ram_data2),
    .run         (run),
    .done_sg     (done_sg),
    .busy        (busy),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .addr_err    (addr_err),
    .wr_count    (wr_count)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    ram_add1 = 16'h0; ram_add2 = 16'h0; mem_write = 1'b0; data_to_ram = 16'h0;
    run = 1'b0; done_sg = 1'b0; host_valid = 1'b0; host_we = 1'b0;
    host_addr = 16'h0; host_wdata = 16'h0;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [15:0] d);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    cyc();
    host_valid = 1'b0; host_we = 1'b0;
  endtask

  // Leaves the bench one falling edge after accept: host_rvalid should be high now.
  task automatic host_read(input logic [15:0] a);
    host_valid = 1'b1; host_we = 1'b0; host_addr = a;
    cyc();
    host_valid = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b0;
    #1;
    checks++; if ({busy, host_rvalid, addr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, host_rvalid, addr_err}); end
    checks++; if ({ram_data1, ram_data2, host_rdata, wr_count} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {ram_data1, ram_data2, host_rdata, wr_count}); end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", host_ready); end
  endtask

  task automatic test_host_load();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0080; exp_v[1] = 16'h0100; exp_v[2] = 16'h0200;
    host_write(M_ADDR,  16'h0080);
    host_write(T0_ADDR, 16'h0100);
    host_write(T1_ADDR, 16'h0200);
    host_write(U0_ADDR, 16'hAAAA);
    host_write(16'd11,  16'h1111);
    host_write(U0_ADDR + U_OFFSET, 16'h0F0F);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", host_rvalid); end
    // Back-to-back reads, one per cycle.
    host_valid = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_addr = 16'(i);
      cyc();
      checks++; if (host_rvalid !== 1'b1 || host_rdata !== exp_v[i]) begin errors++; $display("FAIL host_read_%0d got %b/%h exp 1/%h", i, host_rvalid, host_rdata, exp_v[i]); end
    end
    host_valid = 1'b0;
    cyc();
    checks++; if (host_rvalid !== 1'b0 || host_rdata !== 16'h0200) begin errors++; $display("FAIL rdata_hold got %b/%h exp 0/0200", host_rvalid, host_rdata); end
  endtask

  task automatic test_run_read();
    run = 1'b1;
    host_valid = 1'b1; host_we = 1'b1; host_addr = T1_ADDR; host_wdata = 16'hDEAD;
    #1;
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL run_priority got %b exp 0", host_ready); end
    cyc();
    quiet();
    ram_add1 = T0_ADDR; ram_add2 = U0_ADDR;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", busy); end
    cyc();
    checks++; if (ram_data1 !== 16'h0100 || ram_data2 !== 16'hAAAA) begin errors++; $display("FAIL eng_read got %h/%h exp 0100/aaaa", ram_data1, ram_data2); end
    checks++; if (busy !== 1'b1 || host_ready !== 1'b0) begin errors++; $display("FAIL serve_own got %b/%b exp 1/0", busy, host_ready); end
    ram_add1 = T1_ADDR;
    cyc();
    checks++; if (ram_data1 !== 16'h0200) begin errors++; $display("FAIL run_blocked_host got %h exp 0200", ram_data1); end
  endtask

  task automatic test_read_first();
    ram_add1 = U0_ADDR + U_OFFSET; ram_add2 = U0_ADDR + U_OFFSET;
    mem_write = 1'b1; data_to_ram = 16'h1234;
    cyc();
    mem_write = 1'b0;
    checks++; if (ram_data1 !== 16'h0F0F || ram_data2 !== 16'h0F0F) begin errors++; $display("FAIL read_first got %h/%h exp 0f0f/0f0f", ram_data1, ram_data2); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count_1 got %0d exp 1", wr_count); end
    cyc();
    checks++; if (ram_data1 !== 16'h1234) begin errors++; $display("FAIL write_visible got %h exp 1234", ram_data1); end
  endtask

  task automatic test_done_write();
    ram_add2 = 16'd11; mem_write = 1'b1; data_to_ram = 16'h5555; done_sg = 1'b1;
    cyc();
    mem_write = 1'b0; done_sg = 1'b0;
    checks++; if (busy !== 1'b0 || wr_count !== 16'd2) begin errors++; $display("FAIL done_state got %b/%0d exp 0/2", busy, wr_count); end
    checks++; if (ram_data2 !== 16'h1111) begin errors++; $display("FAIL done_old_word got %h exp 1111", ram_data2); end
    // Engine write strobes while IDLE must not touch memory.
    ram_add2 = U0_ADDR; mem_write = 1'b1; data_to_ram = 16'hBEEF;
    cyc();
    mem_write = 1'b0;
    host_read(16'd11);
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h5555) begin errors++; $display("FAIL done_write got %b/%h exp 1/5555", host_rvalid, host_rdata); end
    checks++; if (ram_data1 !== 16'h1234 || ram_data2 !== 16'h1111) begin errors++; $display("FAIL idle_hold got %h/%h exp 1234/1111", ram_data1, ram_data2); end
    host_read(U0_ADDR);
    checks++; if (host_rdata !== 16'hAAAA) begin errors++; $display("FAIL idle_mem_write got %h exp aaaa", host_rdata); end
  endtask

  task automatic test_out_of_range();
    host_write(16'h0400, 16'h7777);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_flag got %b exp 1", addr_err); end
    host_read(16'h0400);
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 16'h0000) begin errors++; $display("FAIL oor_read got %b/%h exp 1/0000", host_rvalid, host_rdata); end
    host_read(M_ADDR);
    checks++; if (host_rdata !== 16'h0080 || addr_err !== 1'b1) begin errors++; $display("FAIL oor_no_alias got %h/%b exp 0080/1", host_rdata, addr_err); end
    run = 1'b1;
    cyc();
    run = 1'b0;
    checks++; if (addr_err !== 1'b0 || wr_count !== 16'd0) begin errors++; $display("FAIL run_clears got %b/%0d exp 0/0", addr_err, wr_count); end
    ram_add1 = 16'h0400;
    cyc();
    ram_add1 = 16'h0;
    checks++; if (ram_data1 !== 16'h0000 || addr_err !== 1'b1) begin errors++; $display("FAIL eng_oor got %h/%b exp 0000/1", ram_data1, addr_err); end
    done_sg = 1'b1;
    cyc();
    done_sg = 1'b0;
  endtask

  task automatic test_reset_mid_serve();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'hA001; exp_v[1] = 16'hA002; exp_v[2] = 16'hA003;
    run = 1'b1;
    cyc();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ram_add2 = 16'(20 + i); data_to_ram = exp_v[i]; mem_write = 1'b1; ram_add1 = 16'(20 + i);
      cyc();
    end
    mem_write = 1'b0;
    checks++; if (wr_count !== 16'd3 || busy !== 1'b1) begin errors++; $display("FAIL mid_count got %0d/%b exp 3/1", wr_count, busy); end
    rst = 1'b0;
    #1;
    checks++; if ({busy, host_rvalid, addr_err, host_ready} !== 4'b0001) begin errors++; $display("FAIL mid_rst_flags got %b exp 0001", {busy, host_rvalid, addr_err, host_ready}); end
    checks++; if ({ram_data1, ram_data2, host_rdata, wr_count} !== 64'h0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", {ram_data1, ram_data2, host_rdata, wr_count}); end
    cyc();
    quiet();
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      host_read(16'(20 + i));
      checks++; if (host_rvalid !== 1'b1 || host_rdata !== exp_v[i]) begin errors++; $display("FAIL retained_%0d got %b/%h exp 1/%h", i, host_rvalid, host_rdata, exp_v[i]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    test_reset();
    test_host_load();
    test_run_read();
    test_read_first();
    test_done_write();
    test_out_of_range();
    test_reset_mid_serve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
